btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Multi-channel push-button front end: per-channel 2-FF synchroniser, counter-based
//  debounce (both edges), single-cycle press/release pulses. Sits between board pins
//  and game/control FSMs. Replaces fixed 6-tap debounce + one-pulse pairs with one block.
// PARAMETERS
//  N_CH       4     number of independent button channels (>=1)
//  DEB_CNT    16    consecutive identical sync samples required to change state (>=1)
//  ACT_LOW    0     1: pin is low when pressed (inverted before sync); 0: high = pressed
//  REP_DLY    1000  cycles held after press before first repeat pulse (AUTO_REPEAT_EN)
//  REP_PER    200   cycles between subsequent repeat pulses (AUTO_REPEAT_EN, >=1)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous active-low reset
//  btn_in     in   N_CH  raw button pins, asynchronous
//  btn_lvl    out  N_CH  debounced level, 1 = pressed
//  press_p    out  N_CH  one-cycle pulse on debounced 0->1
//  release_p  out  N_CH  one-cycle pulse on debounced 1->0
//  rep_p      out  N_CH  one-cycle auto-repeat pulse while held
//  any_press  out  1     OR of press_p, registered with it (same cycle)
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync FFs, counters, btn_lvl, all pulses, any_press -> 0.
//    Reset mid-debounce/mid-hold discards progress; no pulse on reset release even
//    if pin is held (held pin is re-qualified and yields press_p DEB_CNT cycles later).
//  - Sync: s0<=pin^ACT_LOW, s1<=s0. Counting uses s1 only.
//  - Debounce per channel, counter cnt width $clog2(DEB_CNT+1):
//      s1==btn_lvl -> cnt<=0.
//      s1!=btn_lvl and cnt<DEB_CNT-1 -> cnt<=cnt+1.
//      s1!=btn_lvl and cnt==DEB_CNT-1 -> btn_lvl<=s1, cnt<=0.
//    Glitch shorter than DEB_CNT sync samples: no output change, cnt restarts.
//  - Latency: pin changes and holds from edge k -> btn_lvl and pulse change after
//    edge k+1+DEB_CNT (2 sync stages + DEB_CNT samples, first sample at k+2).
//  - press_p/release_p: registered, high exactly in the first cycle btn_lvl shows new
//    value; never both high on one channel; channels fully independent, any number
//    may pulse in the same cycle.
//  - Pulses have no gating input; downstream consumes every pulse.
// CONFIGURATION
//  Macro AUTO_REPEAT_EN:
//   defined: per-channel hold counter (width $clog2(max(REP_DLY,REP_PER)+1)) cleared
//    on press_p. While btn_lvl=1: rep_p after REP_DLY cycles counted from the press_p
//    cycle, then every REP_PER cycles. press_p cycle itself never carries rep_p.
//    Release or reset clears counter immediately; no rep_p in release_p cycle.
//    Counter saturates-free: reloads each period, no wrap artefacts for long holds.
//   undefined: rep_p tied 0, no hold counters synthesised; REP_* ignored.
// TESTING
//  1 Reset: rst_n=0 with btn_in all 1 -> all outputs 0; release rst_n, hold ->
//    press_p once at cycle DEB_CNT+1 after first post-reset edge, btn_lvl stays 1.
//  2 DEB_CNT=16, ch0 clean press at edge 10 -> btn_lvl[0]=1 and press_p[0]=1 for one
//    cycle after edge 27; any_press same cycle; release -> release_p[0] 17 edges later.
//  3 Bounce: ch1 toggles every 5 cycles for 100 cycles then holds 1 -> exactly one
//    press_p[1], no release_p[1], timed DEB_CNT+1 after final toggle.
//  4 Glitch: 15-cycle high pulse on ch2 (DEB_CNT=16) -> no output change; 16-cycle
//    pulse -> press_p then release_p.
//  5 Simultaneous: ch0 press and ch3 release aligned -> press_p[0], release_p[3] same
//    cycle; any_press=1; ACT_LOW=1 run inverts pin sense with identical timing.
//  6 AUTO_REPEAT_EN, REP_DLY=50, REP_PER=10: hold 100 cycles after press_p ->
//    rep_p at +50,+60,...,+100; release -> no further rep_p; macro off -> rep_p=0.

Source files
------------

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: 2-FF synchroniser, counter debounce on both edges,
// one-cycle press/release pulses. Define AUTO_REPEAT_EN to add per-channel hold-repeat pulses.
module btn_conditioner #(
    parameter int N_CH    = 4,
    parameter int DEB_CNT = 16,
    parameter int ACT_LOW = 0,
    parameter int REP_DLY = 1000,
    parameter int REP_PER = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] rep_p,
    output logic            any_press
);

    localparam int                CNT_W    = $clog2(DEB_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic              INV      = (ACT_LOW != 0);

    logic [N_CH-1:0] press_vec_d;
    logic            any_q;
    logic            any_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             s0_q, s0_d, s1_q, s1_d;
            logic             lvl_q, lvl_d;
            logic             press_q, press_d, rel_q, rel_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // cnt tracks how many consecutive synced samples disagree with the current level
            always_comb begin
                s0_d    = btn_in[gi] ^ INV;
                s1_d    = s0_q;
                cnt_d   = cnt_q;
                lvl_d   = lvl_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
                if (s1_q == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d   = s1_q;
                    cnt_d   = '0;
                    press_d = s1_q;
                    rel_d   = ~s1_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_q    <= 1'b0;
                    s1_q    <= 1'b0;
                    cnt_q   <= '0;
                    lvl_q   <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    s0_q    <= s0_d;
                    s1_q    <= s1_d;
                    cnt_q   <= cnt_d;
                    lvl_q   <= lvl_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                end
            end

            assign btn_lvl[gi]     = lvl_q;
            assign press_p[gi]     = press_q;
            assign release_p[gi]   = rel_q;
            assign press_vec_d[gi] = press_d;

`ifdef AUTO_REPEAT_EN
            localparam int               HOLD_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
            localparam int               HOLD_W   = $clog2(HOLD_MAX + 1);
            localparam logic [HOLD_W-1:0] DLY_V   = HOLD_W'(REP_DLY);
            localparam logic [HOLD_W-1:0] PER_V   = HOLD_W'(REP_PER);

            logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
            logic              started_q, started_d;
            logic              rep_q, rep_d;

            // hold_q counts cycles since the press (or since the last repeat), reloading each period
            always_comb begin
                hold_inc  = hold_q + 1'b1;
                hold_d    = hold_q;
                started_d = started_q;
                rep_d     = 1'b0;
                if (!lvl_d || press_d) begin
                    hold_d    = '0;
                    started_d = 1'b0;
                end else if (hold_inc == (started_q ? PER_V : DLY_V)) begin
                    rep_d     = 1'b1;
                    hold_d    = '0;
                    started_d = 1'b1;
                end else begin
                    hold_d = hold_inc;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q    <= '0;
                    started_q <= 1'b0;
                    rep_q     <= 1'b0;
                end else begin
                    hold_q    <= hold_d;
                    started_q <= started_d;
                    rep_q     <= rep_d;
                end
            end

            assign rep_p[gi] = rep_q;
`else
            assign rep_p[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        any_d = |press_vec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign any_press = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised + directed bench for btn_conditioner; an active-high and an active-low
// instance see complementary pins and are both compared against a sample-window model.
module tb_btn_conditioner;
    localparam int N_CH = 4;
    localparam int DEB  = 16;
    localparam int DLY  = 50;
    localparam int PER  = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] btn_n;
    logic [N_CH-1:0] lvl_a, press_a, rel_a, rep_a;
    logic [N_CH-1:0] lvl_b, press_b, rel_b, rep_b;
    logic            any_a, any_b;

    always #5 clk = ~clk;
    assign btn_n = ~btn;

    btn_conditioner #(.N_CH(N_CH), .DEB_CNT(DEB), .ACT_LOW(0), .REP_DLY(DLY), .REP_PER(PER)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .btn_in(btn), .btn_lvl(lvl_a), .press_p(press_a),
        .release_p(rel_a), .rep_p(rep_a), .any_press(any_a));

    btn_conditioner #(.N_CH(N_CH), .DEB_CNT(DEB), .ACT_LOW(1), .REP_DLY(DLY), .REP_PER(PER)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_n), .btn_lvl(lvl_b), .press_p(press_b),
        .release_p(rel_b), .rep_p(rep_b), .any_press(any_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Model: level flips once the last DEB synced samples (all taken since the previous
    // flip) disagree with it; synced sample at edge e is the pin seen at edge e-2.
    bit pin_hist [N_CH][$];
    bit samp     [N_CH][$];
    bit m_lvl    [N_CH];
    int m_last   [N_CH];
    int m_press_e[N_CH];
    int e;

    int tk;
    int press_cnt[N_CH], rel_cnt[N_CH], rep_cnt[N_CH];
    int p_edge[N_CH], r_edge[N_CH], rep_last[N_CH];
    bit any_at_press;

    function automatic void model_reset();
        e = 0;
        for (int c = 0; c < N_CH; c++) begin
            pin_hist[c].delete();
            samp[c].delete();
            m_lvl[c]     = 1'b0;
            m_last[c]    = -1;
            m_press_e[c] = 0;
        end
    endfunction

    function automatic void clear_stats();
        for (int c = 0; c < N_CH; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0;
            p_edge[c] = -1; r_edge[c] = -1; rep_last[c] = -1;
        end
        any_at_press = 1'b0;
    endfunction

    task automatic tick();
        logic [N_CH-1:0] x_lvl, x_press, x_rel, x_rep;
        bit s, all_diff;
        int d;
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            pin_hist[c].push_back(btn[c]);
            s = (e >= 2) ? pin_hist[c][e-2] : 1'b0;
            samp[c].push_back(s);
            x_press[c] = 1'b0;
            x_rel[c]   = 1'b0;
            x_rep[c]   = 1'b0;
            if (e - m_last[c] >= DEB) begin
                all_diff = 1'b1;
                for (int j = e - DEB + 1; j <= e; j++)
                    if (samp[c][j] == m_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[c]   = ~m_lvl[c];
                    m_last[c]  = e;
                    x_press[c] = m_lvl[c];
                    x_rel[c]   = ~m_lvl[c];
                    if (m_lvl[c]) m_press_e[c] = e;
                end
            end
`ifdef AUTO_REPEAT_EN
            d = e - m_press_e[c];
            x_rep[c] = m_lvl[c] && !x_press[c] && d >= DLY && ((d - DLY) % PER == 0);
`else
            d = 0;
`endif
            x_lvl[c] = m_lvl[c];
        end
        e++;
        check("lvl_hi",   lvl_a,   x_lvl);
        check("press_hi", press_a, x_press);
        check("rel_hi",   rel_a,   x_rel);
        check("rep_hi",   rep_a,   x_rep);
        check("any_hi",   any_a,   |x_press);
        check("lvl_lo",   lvl_b,   x_lvl);
        check("press_lo", press_b, x_press);
        check("rel_lo",   rel_b,   x_rel);
        check("rep_lo",   rep_b,   x_rep);
        check("any_lo",   any_b,   |x_press);
        for (int c = 0; c < N_CH; c++) begin
            if (press_a[c]) begin press_cnt[c]++; p_edge[c] = tk; if (any_a) any_at_press = 1'b1; end
            if (rel_a[c])   begin rel_cnt[c]++;   r_edge[c] = tk; end
            if (rep_a[c])   begin rep_cnt[c]++;   rep_last[c] = tk; end
        end
        tk++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lvl"}, {lvl_a, lvl_b}, '0);
        check({tag, "_pulse"}, {press_a, rel_a, rep_a, press_b, rel_b, rep_b}, '0);
        check({tag, "_any"}, {any_a, any_b}, '0);
    endtask

    int start;
    int rem[N_CH];

    initial begin
        rst_n = 1'b0;
        btn   = '1;
        tk    = 0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // held pins re-qualify after reset: press at edge DEB+1
        ticks(40);
        check("rst_press_edge", p_edge[0], DEB + 1);
        check("rst_press_cnt", press_cnt[0], 1);
        check("rst_lvl", lvl_a, 4'hf);

        btn = '0;
        ticks(40);

        // clean press / release latency on ch0
        clear_stats();
        ticks(10);
        btn[0] = 1'b1;
        start  = tk;
        ticks(30);
        check("press_lat", p_edge[0] - start, DEB + 1);
        check("press_any", any_at_press, 1);
        btn[0] = 1'b0;
        start  = tk;
        ticks(30);
        check("rel_lat", r_edge[0] - start, DEB + 1);

        // bounce on ch1 then settle high
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            btn[1] = ~btn[1];
            ticks(5);
        end
        btn[1] = 1'b1;
        start  = tk;
        ticks(40);
        check("bounce_press_cnt", press_cnt[1], 1);
        check("bounce_rel_cnt", rel_cnt[1], 0);
        check("bounce_lat", p_edge[1] - start, DEB + 1);
        btn[1] = 1'b0;
        ticks(40);

        // glitch on ch2: DEB-1 ignored, DEB accepted
        clear_stats();
        btn[2] = 1'b1; ticks(DEB - 1);
        btn[2] = 1'b0; ticks(40);
        check("glitch15_press", press_cnt[2], 0);
        btn[2] = 1'b1; ticks(DEB);
        btn[2] = 1'b0; ticks(40);
        check("glitch16_press", press_cnt[2], 1);
        check("glitch16_rel", rel_cnt[2], 1);

        // ch0 press aligned with ch3 release
        btn[3] = 1'b1; ticks(40);
        clear_stats();
        btn[0] = 1'b1; btn[3] = 1'b0;
        ticks(40);
        check("simul_edge", p_edge[0] - r_edge[3], 0);
        check("simul_any", any_at_press, 1);
        btn = '0;
        ticks(40);

        // long hold on ch0 for auto-repeat
        clear_stats();
        btn[0] = 1'b1;
        ticks(DEB + 2);
        ticks(p_edge[0] + 101 - tk);
`ifdef AUTO_REPEAT_EN
        check("rep_cnt_100", rep_cnt[0], 6);
        check("rep_first", rep_last[0] - p_edge[0], 100);
`else
        check("rep_cnt_off", rep_cnt[0], 0);
`endif
        btn[0] = 1'b0;
        ticks(60);
        check("rep_after_rel", rep_last[0] < r_edge[0], 1);

        // random sustained/bouncy pin activity with one mid-run async reset
        for (int c = 0; c < N_CH; c++) rem[c] = $urandom_range(1, 40);
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(10, 150);
                end
            end
            if (i == 2000) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_async");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
